// File: rtl/debugger_rx.sv
// Debug command receiver: pops 2-bit UART commands and steps, runs or resets the
// target pipeline, then asks the transmitter to dump state. Optional run cap: DBG_RUN_TIMEOUT_EN.
module debugger_rx #(
    parameter int RESET_CYCLES = 2,
    parameter int RUN_TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       global_reset,
    input  logic [1:0] r_data,
    input  logic       rx_empty,
    input  logic       program_finished,
    input  logic       data_sent,
    output logic       rd_uart,
    output logic       pipeline_reset,
    output logic       pipeline_clk,
    output logic       send_data
);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        STEP_HI,
        STEP_LO,
        RUN_HI,
        RUN_LO,
        SWRST,
        SEND
    } state_e;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_STEP  = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;
    localparam logic [1:0] CMD_SWRST = 2'b11;

    localparam int RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             rd_uart_q, rd_uart_d;
    logic             pipeline_reset_q, pipeline_reset_d;
    logic             pipeline_clk_q, pipeline_clk_d;
    logic             send_data_q, send_data_d;
    logic             run_expired;

`ifdef DBG_RUN_TIMEOUT_EN
    localparam int RUN_W = $clog2(RUN_TIMEOUT + 1);

    logic [RUN_W-1:0] run_cnt_q, run_cnt_d;

    assign run_expired = (run_cnt_q >= RUN_W'(RUN_TIMEOUT));

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_d;
        end
    end
`else
    assign run_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge global_reset) begin
        if (!global_reset) begin
            state_q          <= IDLE;
            cmd_q            <= CMD_NOP;
            rst_cnt_q        <= '0;
            rd_uart_q        <= 1'b0;
            pipeline_reset_q <= 1'b1;
            pipeline_clk_q   <= 1'b0;
            send_data_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            cmd_q            <= cmd_d;
            rst_cnt_q        <= rst_cnt_d;
            rd_uart_q        <= rd_uart_d;
            pipeline_reset_q <= pipeline_reset_d;
            pipeline_clk_q   <= pipeline_clk_d;
            send_data_q      <= send_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        rst_cnt_d = rst_cnt_q;
        rd_uart_d = 1'b0;
`ifdef DBG_RUN_TIMEOUT_EN
        run_cnt_d = run_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_empty) begin
                    cmd_d     = r_data;
                    rd_uart_d = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                case (cmd_q)
                    CMD_STEP: state_d = program_finished ? SEND : STEP_HI;
                    CMD_RUN: begin
                        state_d = program_finished ? SEND : RUN_HI;
`ifdef DBG_RUN_TIMEOUT_EN
                        run_cnt_d = '0;
`endif
                    end
                    CMD_SWRST: begin
                        state_d   = SWRST;
                        rst_cnt_d = '0;
                    end
                    default: state_d = IDLE;
                endcase
            end
            STEP_HI: state_d = STEP_LO;
            STEP_LO: state_d = SEND;
            RUN_HI: begin
                state_d = RUN_LO;
`ifdef DBG_RUN_TIMEOUT_EN
                run_cnt_d = run_cnt_q + RUN_W'(1);
`endif
            end
            RUN_LO: state_d = (program_finished || run_expired) ? SEND : RUN_HI;
            SWRST: begin
                if (rst_cnt_q == RST_W'(RESET_CYCLES - 1)) begin
                    state_d = SEND;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            SEND: begin
                if (data_sent) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the registers line up with state_q.
        pipeline_clk_d   = (state_d == STEP_HI) || (state_d == RUN_HI);
        pipeline_reset_d = (state_d == SWRST);
        send_data_d      = (state_d == SEND);
    end

    assign rd_uart        = rd_uart_q;
    assign pipeline_reset = pipeline_reset_q;
    assign pipeline_clk   = pipeline_clk_q;
    assign send_data      = send_data_q;

endmodule

// File: tb/tb_debugger_rx.sv
// Self-checking bench for debugger_rx: table vectors, randomized commands against a
// command-level model, and hand-written reset/abort/ignore sequences.
module tb_debugger_rx;

    localparam int RESET_CYCLES = 2;
`ifdef DBG_RUN_TIMEOUT_EN
    localparam int RUN_TO = 8;
`else
    localparam int RUN_TO = 1024;
`endif
    localparam int EXP_LONG = (RUN_TO < 20) ? RUN_TO : 20;

    logic       clk;
    logic       global_reset;
    logic [1:0] r_data;
    logic       rx_empty;
    logic       program_finished;
    logic       data_sent;
    logic       rd_uart;
    logic       pipeline_reset;
    logic       pipeline_clk;
    logic       send_data;

    int nChecks;
    int nFails;

    debugger_rx #(
        .RESET_CYCLES(RESET_CYCLES),
        .RUN_TIMEOUT (RUN_TO)
    ) dut (
        .clk             (clk),
        .global_reset    (global_reset),
        .r_data          (r_data),
        .rx_empty        (rx_empty),
        .program_finished(program_finished),
        .data_sent       (data_sent),
        .rd_uart         (rd_uart),
        .pipeline_reset  (pipeline_reset),
        .pipeline_clk    (pipeline_clk),
        .send_data       (send_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic       fin;
        int         runLen;
        int         eEdge;
        int         eRst;
        int         eHs;
    } vec_t;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Command-level reference: what one command should produce on the pipeline side.
    function automatic void model(input logic [1:0] cmd, input logic fin, input int runLen,
                                  output int eEdge, output int eRst, output int eHs);
        eRst = (cmd == 2'b11) ? RESET_CYCLES : 0;
        eHs  = (cmd != 2'b00) ? 1 : 0;
        case (cmd)
            2'b01:   eEdge = fin ? 0 : 1;
            2'b10:   eEdge = fin ? 0 : ((runLen < RUN_TO) ? runLen : RUN_TO);
            default: eEdge = 0;
        endcase
    endfunction

    // Issues one command, plays end detector and transmitter, and measures the response.
    // hs: 1 = send_data seen and dropped right after data_sent, 2 = it did not drop, 0 = none.
    task automatic applyStimulus(input logic [1:0] cmd, input logic fin, input int runLen,
                                 output int rdC, output int edgeC, output int rstC,
                                 output int sendC, output int hs);
        logic prevP;
        logic prevS;
        bit   done;
        int   sendHigh;
        int   waitDelay;
        @(negedge clk);
        data_sent        = 1'b0;
        program_finished = fin;
        r_data           = cmd;
        rx_empty         = 1'b0;
        rdC = 0; edgeC = 0; rstC = 0; sendC = 0; hs = 0;
        prevP = 1'b0; prevS = 1'b0; done = 1'b0; sendHigh = 0;
        waitDelay = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                rx_empty = 1'b1;
                r_data   = 2'($urandom);
            end
            if (rd_uart) rdC++;
            if (pipeline_clk && !prevP) edgeC++;
            if (pipeline_reset) rstC++;
            if (send_data && !prevS) sendC++;
            prevP = pipeline_clk;
            prevS = send_data;
            if (runLen > 0 && edgeC >= runLen) program_finished = 1'b1;
            if (data_sent) begin
                data_sent = 1'b0;
                hs   = send_data ? 2 : 1;
                done = 1'b1;
            end else if (send_data) begin
                if (sendHigh == waitDelay) data_sent = 1'b1;
                sendHigh++;
            end
            if (cmd == 2'b00 && cyc >= 5) done = 1'b1;
        end
    endtask

    task automatic runVector(input string tag, input logic [1:0] cmd, input logic fin,
                             input int runLen, input int eEdge, input int eRst, input int eHs);
        int rdC, edgeC, rstC, sendC, hs;
        applyStimulus(cmd, fin, runLen, rdC, edgeC, rstC, sendC, hs);
        checkOutput({tag, " rd_uart pulses"}, rdC, 1);
        checkOutput({tag, " pipeline_clk edges"}, edgeC, eEdge);
        checkOutput({tag, " pipeline_reset cycles"}, rstC, eRst);
        checkOutput({tag, " send_data requests"}, sendC, eHs);
        checkOutput({tag, " handshake"}, hs, eHs);
    endtask

    task automatic waitSend(output int ok);
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            if (send_data) ok = 1;
        end
    endtask

    task automatic waitEdges(input int n, output int ok);
        int cnt;
        logic prevP;
        cnt = 0; prevP = 1'b0; ok = 0;
        for (int i = 0; i < 100 && ok == 0; i++) begin
            @(negedge clk);
            if (pipeline_clk && !prevP) cnt++;
            prevP = pipeline_clk;
            if (cnt >= n) ok = 1;
        end
    endtask

    task automatic hardReset();
        int bad;
        @(negedge clk);
        global_reset = 1'b0;
        rx_empty     = 1'b0;
        data_sent    = 1'b1;
        #1;
        checkOutput("async reset pipeline_reset", int'(pipeline_reset), 1);
        checkOutput("async reset pipeline_clk", int'(pipeline_clk), 0);
        checkOutput("async reset send_data", int'(send_data), 0);
        checkOutput("async reset rd_uart", int'(rd_uart), 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rd_uart || send_data || pipeline_clk || !pipeline_reset) bad++;
        end
        checkOutput("outputs held during reset", bad, 0);
        rx_empty     = 1'b1;
        data_sent    = 1'b0;
        global_reset = 1'b1;
        @(negedge clk);
        checkOutput("pipeline_reset drops after release", int'(pipeline_reset), 0);
    endtask

    vec_t vecs[9];

    initial begin
        int ok, rdDuring, rdAfter, eEdge, eRst, eHs;
        logic [1:0] cmd;
        logic fin;
        int runLen;

        nChecks = 0;
        nFails  = 0;
        global_reset     = 1'b0;
        r_data           = 2'b00;
        rx_empty         = 1'b1;
        program_finished = 1'b0;
        data_sent        = 1'b0;

        vecs[0] = '{2'b01, 1'b0, 0,  1,        0,            1};
        vecs[1] = '{2'b01, 1'b1, 0,  0,        0,            1};
        vecs[2] = '{2'b10, 1'b0, 5,  5,        0,            1};
        vecs[3] = '{2'b10, 1'b1, 3,  0,        0,            1};
        vecs[4] = '{2'b10, 1'b0, 1,  1,        0,            1};
        vecs[5] = '{2'b11, 1'b0, 0,  0,        RESET_CYCLES, 1};
        vecs[6] = '{2'b11, 1'b1, 0,  0,        RESET_CYCLES, 1};
        vecs[7] = '{2'b00, 1'b0, 0,  0,        0,            0};
        vecs[8] = '{2'b10, 1'b0, 20, EXP_LONG, 0,            1};

        // Power-on reset: pipeline held in reset, everything else quiet.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("power-on pipeline_reset", int'(pipeline_reset), 1);
            checkOutput("power-on quiet outputs", int'(rd_uart | send_data | pipeline_clk), 0);
        end
        global_reset = 1'b1;
        @(negedge clk);
        checkOutput("pipeline_reset after power-on", int'(pipeline_reset), 0);

        foreach (vecs[i]) begin
            runVector($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].fin, vecs[i].runLen,
                      vecs[i].eEdge, vecs[i].eRst, vecs[i].eHs);
        end

        // A command queued while SEND is active must wait until IDLE.
        @(negedge clk);
        program_finished = 1'b0;
        r_data   = 2'b01;
        rx_empty = 1'b0;
        @(negedge clk);
        rx_empty = 1'b1;
        waitSend(ok);
        checkOutput("step reaches send", ok, 1);
        r_data   = 2'b00;
        rx_empty = 1'b0;
        rdDuring = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rd_uart) rdDuring++;
        end
        checkOutput("no pop during send", rdDuring, 0);
        checkOutput("send held without ack", int'(send_data), 1);
        data_sent = 1'b1;
        @(negedge clk);
        data_sent = 1'b0;
        checkOutput("send drops after ack", int'(send_data), 0);
        rdAfter = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (rd_uart) begin
                rdAfter++;
                rx_empty = 1'b1;
            end
        end
        rx_empty = 1'b1;
        checkOutput("queued command popped after idle", rdAfter, 1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a run.
        program_finished = 1'b0;
        r_data   = 2'b10;
        rx_empty = 1'b0;
        @(negedge clk);
        rx_empty = 1'b1;
        waitEdges(3, ok);
        checkOutput("run produces edges", ok, 1);
        hardReset();
        runVector("post-run-abort step", 2'b01, 1'b0, 0, 1, 0, 1);

        // Reset while waiting in SEND.
        @(negedge clk);
        r_data   = 2'b11;
        rx_empty = 1'b0;
        @(negedge clk);
        rx_empty = 1'b1;
        waitSend(ok);
        checkOutput("swreset reaches send", ok, 1);
        hardReset();

        for (int n = 0; n < 25; n++) begin
            cmd    = 2'($urandom_range(0, 3));
            fin    = ($urandom_range(0, 3) == 0);
            runLen = $urandom_range(1, 12);
            model(cmd, fin, runLen, eEdge, eRst, eHs);
            runVector($sformatf("rand%0d cmd%0d", n, cmd), cmd, fin, runLen, eEdge, eRst, eHs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
